rxn_timer: RTL

Reaction-time measurement stage of the reaction speed game. It sits directly downstream of the game FSM. It consumes `led_flag`, which starts timing, and `delay_flag`, which enables false-start detection, and it returns `rxn_done` to the FSM. It synchronizes and edge-detects the player's push-button, counts elapsed time in 4-digit BCD at a configurable tick rate, and holds the result for the display stage.

---
 rtl/rxn_pkg.sv | 16 +
 rtl/bcd_counter.sv | 47 ++++
 rtl/rxn_timer.sv | 109 ++++++++++
 3 files changed

// File: rtl/rxn_pkg.sv
// Shared types and constants for the reaction-time measurement stage.
package rxn_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StDone,
    StFoul
  } rxn_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam bcd_digit_t  BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// Four-digit BCD counter with synchronous clear and saturating increment at 9999.
module bcd_counter
  import rxn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value,
  output logic        at_max
);

  bcd_digit_t [3:0] digits_q;
  bcd_digit_t [3:0] digits_d;
  logic             carry;

  assign value  = digits_q;
  assign at_max = (digits_q == BCD_MAX);

  always_comb begin
    digits_d = digits_q;
    carry    = inc & ~at_max;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        // A digit that is somehow above 9 also wraps, so digits stay legal.
        if (digits_q[i] >= BCD_NINE) begin
          digits_d[i] = '0;
        end else begin
          digits_d[i] = digits_q[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    if (clr) begin
      digits_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

endmodule

// File: rtl/rxn_timer.sv
// Reaction timer: button conditioning, tick prescaler, measurement FSM, BCD result.
module rxn_timer
  import rxn_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        delay_flag,
  input  logic        led_flag,
  input  logic        btn,
  output logic        rxn_done,
  output logic        false_start,
  output logic        overflow,
  output logic [15:0] rxn_bcd
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  rxn_state_t    state_q;
  logic          sync1_q;
  logic          sync2_q;
  logic          prev_q;
  logic          btn_rise;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          at_max;
  logic          foul_evt;
  logic          cnt_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Level alone never stops the timer: a button held through led_flag must be re-pressed.
  assign btn_rise = sync2_q & ~prev_q;

  assign tick = (state_q == StCount) && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (state_q != StCount || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign foul_evt = (state_q == StIdle) && delay_flag && btn_rise;
  assign cnt_clr  = (state_q == StIdle) && (foul_evt || led_flag);

  bcd_counter u_bcd (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (tick),
    .value  (rxn_bcd),
    .at_max (at_max)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      rxn_done    <= 1'b0;
      false_start <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (foul_evt) begin
            state_q     <= StFoul;
            rxn_done    <= 1'b1;
            false_start <= 1'b1;
          end else if (led_flag) begin
            state_q <= StCount;
          end
        end
        StCount: begin
          // A tick coinciding with the press is still counted by u_bcd this cycle.
          if (btn_rise || (tick && at_max)) begin
            state_q  <= StDone;
            rxn_done <= 1'b1;
            if (tick && at_max) begin
              overflow <= 1'b1;
            end
          end else if (!led_flag) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

endmodule
